trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Initiator side of the CSR command port: drives the M-mode CSR file to perform trap entry and MRET return.
//  Sits between the pipeline's exception/commit logic and the CSR unit; emits one CSR command per cycle,
//  then issues a single-cycle PC redirect. The CSR unit reads combinationally and writes on the clk edge.
// PARAMETERS
//  XLEN         32  data width of CSR values and PCs
//  VECTORED_EN  1   1: honour mtvec.MODE=01 for interrupts; 0: always direct mode
// PORTS
//  clk            in   1     system clock
//  nrst           in   1     asynchronous active-low reset
//  trap_req       in   1     request trap entry (sampled only when req_ready=1)
//  trap_cause     in   XLEN  mcause value; bit XLEN-1 = interrupt
//  trap_epc       in   XLEN  faulting/interrupted PC
//  trap_tval      in   XLEN  mtval value
//  mret_req       in   1     request MRET return (sampled only when req_ready=1)
//  req_ready      out  1     1 in IDLE: requests accepted this cycle
//  csr_index      out  12    CSR address (rv32ima_pkg CSR_* constants)
//  csr_opcode     out  3     CSRRW / CSRRS encodings from rv32ima_pkg
//  csr_ren        out  1     read enable
//  csr_wen        out  1     write enable
//  csr_reg_val    out  XLEN  write data
//  csr_val        in   XLEN  read data returned by the CSR unit (same cycle)
//  redirect_valid out  1     one-cycle pulse: fetch must jump to redirect_pc
//  redirect_pc    out  XLEN  target PC; holds last value until next redirect
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE; capture regs, redirect_pc, redirect_valid, all csr_* outputs = 0.
//  Read command:  opcode=CSRRS, ren=1, wen=0, reg_val=0. Write command: opcode=CSRRW, ren=0, wen=1.
//  Idle cycles: csr_ren=csr_wen=0, index=0, opcode=0 (CSR unit treats as no-op).
//  Accept: in IDLE, trap_req=1 -> latch cause/epc/tval, go T_EPC. Else mret_req=1 -> R_MST_RD.
//   Both asserted in the same cycle: trap wins; mret is dropped (requester must re-assert).
//   Requests while req_ready=0 are ignored, not queued.
//  Trap FSM (one CSR command per state, one cycle each):
//   T_EPC    write MEPC  <= epc & ~1
//   T_CAUSE  write MCAUSE <= cause
//   T_TVAL   write MTVAL <= tval
//   T_MST_RD read MSTATUS; latch into mst_q
//   T_MST_WR write MSTATUS <= mst_q with MPIE(7)=mst_q[3], MIE(3)=0, MPP(12:11)=2'b11
//   T_VEC    read MTVEC; base = csr_val & ~3; if VECTORED_EN && csr_val[1:0]==2'b01 && cause[XLEN-1]
//            target = base + (cause[XLEN-2:0] << 2) (mod 2^XLEN), else target = base; -> REDIR
//  MRET FSM:
//   R_MST_RD read MSTATUS; latch mst_q
//   R_MST_WR write MSTATUS <= mst_q with MIE(3)=mst_q[7], MPIE(7)=1, MPP=2'b11
//   R_EPC    read MEPC; target = csr_val & ~1; -> REDIR
//  REDIR: redirect_valid=1, redirect_pc=target (registered, valid in this cycle); next -> IDLE.
//  Latency: trap request to redirect_valid = 7 cycles; mret = 4 cycles. req_ready=0 in all non-IDLE states.
//  Reset mid-sequence: abort immediately, no redirect; partially written CSRs are not rolled back.
//  mtvec.MODE=10/11 (reserved): treated as direct.
// TESTING
//  1 trap_req, cause=2, epc=0x100, tval=0xDEAD, mtvec=0x8000, MSTATUS=0x8 -> MEPC=0x100, MCAUSE=2,
//    MTVAL=0xDEAD, MSTATUS=0x1880, redirect_valid pulse 7 cycles later, redirect_pc=0x8000.
//  2 mtvec=0x8001, cause=0x80000007 -> redirect_pc=0x801C; same with cause=7 (exception) -> 0x8000.
//  3 After test 1, mret_req -> MSTATUS=0x1888, redirect_pc=0x100 after 4 cycles, req_ready high next cycle.
//  4 trap_req and mret_req same cycle -> only trap sequence runs; mret_req during busy -> no effect.
//  5 nrst low during T_MST_WR -> outputs 0, state IDLE, no redirect; new trap_req after reset completes normally.
//  6 Check every CSR command cycle: exact index/opcode/ren/wen per state table; idle cycles ren=wen=0.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// CSR command port between trap_sequencer (master) and the M-mode CSR file (slave).
//   csr_index   CSR address driven by the master
//   csr_opcode  CSRRW / CSRRS funct3 encoding (0 = no-op)
//   csr_ren     read enable; csr_val is returned combinationally in the same cycle
//   csr_wen     write enable; the CSR file commits csr_reg_val on the clock edge
//   csr_reg_val write data
//   csr_val     read data driven by the slave
interface trap_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic [11:0]     csr_index;
    logic [2:0]      csr_opcode;
    logic            csr_ren;
    logic            csr_wen;
    logic [XLEN-1:0] csr_reg_val;
    logic [XLEN-1:0] csr_val;

    modport master (
        output csr_index,
        output csr_opcode,
        output csr_ren,
        output csr_wen,
        output csr_reg_val,
        input  csr_val
    );

    modport slave (
        input  csr_index,
        input  csr_opcode,
        input  csr_ren,
        input  csr_wen,
        input  csr_reg_val,
        output csr_val
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry / MRET return sequencer. Drives the M-mode CSR file through a one-command-per-cycle
// CSR port and finishes each sequence with a single-cycle PC redirect.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   trap_req         trap entry request with trap_cause / trap_epc / trap_tval (taken in idle only)
//   mret_req         MRET request (taken in idle only; loses to a simultaneous trap_req)
//   req_ready        high while idle
//   csr              CSR command port (master side)
//   redirect_valid   one-cycle pulse, fetch jumps to redirect_pc
//   redirect_pc      jump target, held until the next redirect
module trap_sequencer #(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    output logic            req_ready,
    trap_sequencer_if.master csr,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMtval   = 12'h343;

    localparam logic [2:0] OpCsrrw = 3'b001;
    localparam logic [2:0] OpCsrrs = 3'b010;

    localparam logic [XLEN-1:0] LowBit  = XLEN'(1);
    localparam logic [XLEN-1:0] LowBits = XLEN'(3);

    typedef enum logic [3:0] {
        StIdle,
        StTEpc,
        StTCause,
        StTTval,
        StTMstRd,
        StTMstWr,
        StTVec,
        StRMstRd,
        StRMstWr,
        StREpc,
        StRedir
    } state_e;

    typedef struct packed {
        logic [11:0]     index;
        logic [2:0]      opcode;
        logic            ren;
        logic            wen;
        logic [XLEN-1:0] val;
    } cmd_t;

    state_e          state_q;
    cmd_t            cmd_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;

    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;
    logic            vec_mode;

    function automatic cmd_t rd_cmd(input logic [11:0] idx);
        cmd_t c;
        c        = '0;
        c.index  = idx;
        c.opcode = OpCsrrs;
        c.ren    = 1'b1;
        return c;
    endfunction

    function automatic cmd_t wr_cmd(input logic [11:0] idx, input logic [XLEN-1:0] v);
        cmd_t c;
        c        = '0;
        c.index  = idx;
        c.opcode = OpCsrrw;
        c.wen    = 1'b1;
        c.val    = v;
        return c;
    endfunction

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r        = v;
        r[7]     = v[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // MRET: MIE <= MPIE, MPIE <= 1, MPP stays M (only M-mode implemented).
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r        = v;
        r[3]     = v[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mtvec decode, valid while the MTVEC read is on the port (StTVec).
    // Reserved MODE values fall through to direct mode.
    always_comb begin
        vec_base = csr.csr_val & ~LowBits;
        vec_off  = {cause_q[XLEN-3:0], 2'b00};
        vec_mode = VECTORED_EN && (csr.csr_val[1:0] == 2'b01) && cause_q[XLEN-1];
    end

    assign req_ready       = (state_q == StIdle);
    assign csr.csr_index   = cmd_q.index;
    assign csr.csr_opcode  = cmd_q.opcode;
    assign csr.csr_ren     = cmd_q.ren;
    assign csr.csr_wen     = cmd_q.wen;
    assign csr.csr_reg_val = cmd_q.val;

    // The command for a state is registered on the edge that enters it, so the CSR unit sees it
    // for exactly that state's cycle and read data can be used on the edge that leaves it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= StIdle;
            cmd_q          <= '0;
            cause_q        <= '0;
            tval_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            cmd_q          <= '0;
            redirect_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trap_req) begin
                        cause_q <= trap_cause;
                        tval_q  <= trap_tval;
                        cmd_q   <= wr_cmd(CsrMepc, trap_epc & ~LowBit);
                        state_q <= StTEpc;
                    end else if (mret_req) begin
                        cmd_q   <= rd_cmd(CsrMstatus);
                        state_q <= StRMstRd;
                    end
                end
                StTEpc: begin
                    cmd_q   <= wr_cmd(CsrMcause, cause_q);
                    state_q <= StTCause;
                end
                StTCause: begin
                    cmd_q   <= wr_cmd(CsrMtval, tval_q);
                    state_q <= StTTval;
                end
                StTTval: begin
                    cmd_q   <= rd_cmd(CsrMstatus);
                    state_q <= StTMstRd;
                end
                StTMstRd: begin
                    // The modified mstatus is captured straight into the write command.
                    cmd_q   <= wr_cmd(CsrMstatus, trap_mstatus(csr.csr_val));
                    state_q <= StTMstWr;
                end
                StTMstWr: begin
                    cmd_q   <= rd_cmd(CsrMtvec);
                    state_q <= StTVec;
                end
                StTVec: begin
                    redirect_pc    <= vec_mode ? (vec_base + vec_off) : vec_base;
                    redirect_valid <= 1'b1;
                    state_q        <= StRedir;
                end
                StRMstRd: begin
                    cmd_q   <= wr_cmd(CsrMstatus, mret_mstatus(csr.csr_val));
                    state_q <= StRMstWr;
                end
                StRMstWr: begin
                    cmd_q   <= rd_cmd(CsrMepc);
                    state_q <= StREpc;
                end
                StREpc: begin
                    redirect_pc    <= csr.csr_val & ~LowBit;
                    redirect_valid <= 1'b1;
                    state_q        <= StRedir;
                end
                StRedir: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [11:0] MTVAL   = 12'h343;
    localparam logic [2:0]  RW      = 3'b001;
    localparam logic [2:0]  RS      = 3'b010;

    logic        clk;
    logic        nrst;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        req_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks;
    int failures;

    // CSR file model
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        poke_en;
    logic [11:0] poke_idx;
    logic [31:0] poke_val;

    trap_sequencer_if #(.XLEN(32)) csr ();

    trap_sequencer #(
        .XLEN       (32),
        .VECTORED_EN(1'b1)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .trap_req      (trap_req),
        .trap_cause    (trap_cause),
        .trap_epc      (trap_epc),
        .trap_tval     (trap_tval),
        .mret_req      (mret_req),
        .req_ready     (req_ready),
        .csr           (csr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        csr.csr_val = '0;
        if (csr.csr_ren) begin
            case (csr.csr_index)
                MSTATUS: csr.csr_val = m_mstatus;
                MTVEC:   csr.csr_val = m_mtvec;
                MEPC:    csr.csr_val = m_mepc;
                MCAUSE:  csr.csr_val = m_mcause;
                MTVAL:   csr.csr_val = m_mtval;
                default: csr.csr_val = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (poke_en) begin
            case (poke_idx)
                MSTATUS: m_mstatus <= poke_val;
                MTVEC:   m_mtvec   <= poke_val;
                default: ;
            endcase
        end else if (csr.csr_wen) begin
            case (csr.csr_index)
                MSTATUS: m_mstatus <= csr.csr_reg_val;
                MTVEC:   m_mtvec   <= csr.csr_reg_val;
                MEPC:    m_mepc    <= csr.csr_reg_val;
                MCAUSE:  m_mcause  <= csr.csr_reg_val;
                MTVAL:   m_mtval   <= csr.csr_reg_val;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(input string tag, input logic [11:0] idx, input logic [2:0] op,
                           input logic ren, input logic wen, input logic [31:0] val);
        chk({tag, ".index"}, 32'(csr.csr_index), 32'(idx));
        chk({tag, ".opcode"}, 32'(csr.csr_opcode), 32'(op));
        chk({tag, ".ren"}, 32'(csr.csr_ren), 32'(ren));
        chk({tag, ".wen"}, 32'(csr.csr_wen), 32'(wen));
        chk({tag, ".reg_val"}, csr.csr_reg_val, val);
        chk({tag, ".ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".redir_v"}, 32'(redirect_valid), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".idle_index"}, 32'(csr.csr_index), 32'd0);
        chk({tag, ".idle_opcode"}, 32'(csr.csr_opcode), 32'd0);
        chk({tag, ".idle_ren"}, 32'(csr.csr_ren), 32'd0);
        chk({tag, ".idle_wen"}, 32'(csr.csr_wen), 32'd0);
        chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".idle_redir_v"}, 32'(redirect_valid), 32'd0);
    endtask

    task automatic poke(input logic [11:0] idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    // Full trap sequence from idle; with_mret also raises mret_req alongside and while busy.
    task automatic run_trap(input string tag, input logic [31:0] cause, input logic [31:0] epc,
                            input logic [31:0] tval, input logic [31:0] exp_mst,
                            input logic [31:0] exp_pc, input bit with_mret);
        chk({tag, ".ready0"}, 32'(req_ready), 32'd1);
        trap_req   = 1'b1;
        trap_cause = cause;
        trap_epc   = epc;
        trap_tval  = tval;
        mret_req   = with_mret;
        @(negedge clk);
        trap_req = 1'b0;
        mret_req = 1'b0;
        chk_cmd({tag, ".mepc"}, MEPC, RW, 1'b0, 1'b1, {epc[31:1], 1'b0});
        @(negedge clk);
        if (with_mret) mret_req = 1'b1;
        chk_cmd({tag, ".mcause"}, MCAUSE, RW, 1'b0, 1'b1, cause);
        @(negedge clk);
        chk_cmd({tag, ".mtval"}, MTVAL, RW, 1'b0, 1'b1, tval);
        @(negedge clk);
        chk_cmd({tag, ".mst_rd"}, MSTATUS, RS, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk_cmd({tag, ".mst_wr"}, MSTATUS, RW, 1'b0, 1'b1, exp_mst);
        @(negedge clk);
        chk_cmd({tag, ".mtvec_rd"}, MTVEC, RS, 1'b1, 1'b0, 32'd0);
        mret_req = 1'b0;
        @(negedge clk);
        chk({tag, ".redir_v"}, 32'(redirect_valid), 32'd1);
        chk({tag, ".redir_pc"}, redirect_pc, exp_pc);
        chk({tag, ".redir_ren"}, 32'(csr.csr_ren), 32'd0);
        chk({tag, ".redir_wen"}, 32'(csr.csr_wen), 32'd0);
        chk({tag, ".redir_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk_idle({tag, ".after"});
        chk({tag, ".pc_hold"}, redirect_pc, exp_pc);
        chk({tag, ".m_mepc"}, m_mepc, {epc[31:1], 1'b0});
        chk({tag, ".m_mcause"}, m_mcause, cause);
        chk({tag, ".m_mtval"}, m_mtval, tval);
        chk({tag, ".m_mstatus"}, m_mstatus, exp_mst);
        if (with_mret) begin
            @(negedge clk);
            chk_idle({tag, ".mret_dropped"});
        end
    endtask

    task automatic run_mret(input string tag, input logic [31:0] exp_mst,
                            input logic [31:0] exp_pc);
        chk({tag, ".ready0"}, 32'(req_ready), 32'd1);
        mret_req = 1'b1;
        @(negedge clk);
        mret_req = 1'b0;
        chk_cmd({tag, ".mst_rd"}, MSTATUS, RS, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk_cmd({tag, ".mst_wr"}, MSTATUS, RW, 1'b0, 1'b1, exp_mst);
        @(negedge clk);
        chk_cmd({tag, ".mepc_rd"}, MEPC, RS, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk({tag, ".redir_v"}, 32'(redirect_valid), 32'd1);
        chk({tag, ".redir_pc"}, redirect_pc, exp_pc);
        chk({tag, ".redir_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk_idle({tag, ".after"});
        chk({tag, ".pc_hold"}, redirect_pc, exp_pc);
        chk({tag, ".m_mstatus"}, m_mstatus, exp_mst);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        nrst       = 1'b0;
        trap_req   = 1'b0;
        trap_cause = '0;
        trap_epc   = '0;
        trap_tval  = '0;
        mret_req   = 1'b0;
        poke_en    = 1'b0;
        poke_idx   = '0;
        poke_val   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.index", 32'(csr.csr_index), 32'd0);
        chk("rst.opcode", 32'(csr.csr_opcode), 32'd0);
        chk("rst.ren", 32'(csr.csr_ren), 32'd0);
        chk("rst.wen", 32'(csr.csr_wen), 32'd0);
        chk("rst.reg_val", csr.csr_reg_val, 32'd0);
        chk("rst.redir_v", 32'(redirect_valid), 32'd0);
        chk("rst.redir_pc", redirect_pc, 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        nrst = 1'b1;
        @(negedge clk);
        chk_idle("rst.released");

        // Basic trap, then MRET back
        poke(MSTATUS, 32'h8);
        poke(MTVEC, 32'h8000);
        run_trap("t1", 32'd2, 32'h100, 32'hDEAD, 32'h1880, 32'h8000, 1'b0);
        run_mret("t3", 32'h1888, 32'h100);

        // Vectored interrupt vs exception, epc bit 0 cleared
        poke(MTVEC, 32'h8001);
        run_trap("t2irq", 32'h8000_0007, 32'h205, 32'h0, 32'h1880, 32'h801C, 1'b0);
        run_trap("t2exc", 32'd7, 32'h300, 32'h44, 32'h1800, 32'h8000, 1'b0);
        run_mret("t2mret", 32'h1880, 32'h300);

        // Simultaneous trap+mret, and mret while busy
        run_trap("t4", 32'h8000_0003, 32'h400, 32'h1, 32'h1800, 32'h800C, 1'b1);

        // Reserved mtvec mode behaves as direct
        poke(MTVEC, 32'h8003);
        run_trap("rsvd", 32'h8000_0005, 32'h500, 32'h0, 32'h1800, 32'h8000, 1'b0);

        // Reset during the mstatus write
        poke(MSTATUS, 32'h8);
        poke(MTVEC, 32'h9000);
        trap_req   = 1'b1;
        trap_cause = 32'd1;
        trap_epc   = 32'h600;
        trap_tval  = 32'h77;
        @(negedge clk);
        trap_req = 1'b0;
        repeat (4) @(negedge clk);
        chk_cmd("t5.mst_wr", MSTATUS, RW, 1'b0, 1'b1, 32'h1880);
        nrst = 1'b0;
        #1;
        chk("t5.index", 32'(csr.csr_index), 32'd0);
        chk("t5.wen", 32'(csr.csr_wen), 32'd0);
        chk("t5.reg_val", csr.csr_reg_val, 32'd0);
        chk("t5.ready", 32'(req_ready), 32'd1);
        chk("t5.redir_pc", redirect_pc, 32'd0);
        @(negedge clk);
        chk("t5.redir_v0", 32'(redirect_valid), 32'd0);
        @(negedge clk);
        chk("t5.redir_v1", 32'(redirect_valid), 32'd0);
        chk("t5.m_mstatus", m_mstatus, 32'h8);
        chk("t5.m_mepc", m_mepc, 32'h600);
        chk("t5.m_mcause", m_mcause, 32'd1);
        nrst = 1'b1;
        @(negedge clk);
        chk_idle("t5.post");
        run_trap("t5new", 32'd4, 32'h700, 32'h88, 32'h1880, 32'h9000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
